// File: rtl/ultra_sonic_array.sv
// ultra_sonic_array
//   Round-robin driver for N_CH HC-SR04-style ultrasonic sensors. A single
//   shared measurement engine triggers one enabled sensor at a time. It times
//   that sensor's echo pulse in clk cycles, or flags a no-echo timeout, and
//   then waits out a holdoff gap before moving on to the next channel.
//   Results, status and control sit on a 32-bit word-addressed register bus.
//
// Optional build macro: ULTRA_SONIC_IRQ_EN
//   Adds per-channel interrupt enables in CONTROL[30:16] and drives a
//   registered level interrupt. When the macro is absent, irq is tied to 0.
//
// Ports
//   clk         system clock
//   reset_all   synchronous active-high reset
//   echo_high   asynchronous echo inputs, one per sensor
//   pulse_out   trigger outputs, at most one high at a time
//   addr        word address
//   read_en     read strobe; read_data is valid one cycle later
//   write_en    write strobe
//   write_data  write data
//   read_data   registered read data; holds its value when read_en=0
//   irq         level interrupt
//
// Register map
//   0      STATUS   [15:0] ready, [31:16] timeout; a read clears them
//   1      CONTROL  [N_CH-1:0] enable mask, [30:16] irq enables,
//                   [31] write-1 soft restart
//   2+i    COUNT[i] zero-extended echo count of channel i
module ultra_sonic_array #(
  parameter int N_CH        = 4,
  parameter int COUNT_WIDTH = 24,
  parameter int TRIG_CYCLES = 500,
  parameter int TIMEOUT     = 1500000,
  parameter int GAP_CYCLES  = 50000,
  parameter int ADDR_W      = 5
) (
  input  logic              clk,
  input  logic              reset_all,
  input  logic [N_CH-1:0]   echo_high,
  output logic [N_CH-1:0]   pulse_out,
  input  logic [ADDR_W-1:0] addr,
  input  logic              read_en,
  input  logic              write_en,
  input  logic [31:0]       write_data,
  output logic [31:0]       read_data,
  output logic              irq
);

  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  typedef enum logic [2:0] {
    IDLE, TRIG, WAIT_ECHO, MEASURE, DONE_OK, DONE_TO, HOLDOFF
  } state_t;

  state_t                 state_reg, state_next;
  logic [CH_W-1:0]        ch_reg, ch_next, scan_ch;
  logic [31:0]            timer_reg, timer_next;
  logic [COUNT_WIDTH-1:0] cnt_reg, cnt_next;
  logic [N_CH-1:0]        mask_reg, ready_reg, ready_next, timeout_reg, timeout_next;
  logic [N_CH-1:0]        pulse_reg, pulse_next;
  logic [N_CH-1:0]        echo_sync, echo_rise, echo_shift, rise_shift, ch_onehot, scan_mask;
  logic [COUNT_WIDTH-1:0] count_mem [N_CH];
  logic [31:0]            read_data_reg, rd_mux, control_word;
  logic                   echo_sel, rise_sel, scan_found, ctrl_wr, restart, stat_rd;
  int                     scan_idx;
  logic                   unused_wdata;

  // Bits of write_data outside the mask, irq-enable and restart fields are don't-care.
  assign unused_wdata = ^write_data;

  assign ctrl_wr = write_en && (addr == ADDR_W'(1));
  assign restart = ctrl_wr && write_data[31];
  assign stat_rd = read_en && (addr == '0);

  // Per-channel 2-flop synchroniser plus one extra stage for edge detection,
  // and per-channel result register.
  for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
    logic                   s1_reg, s2_reg, s3_reg;
    logic [COUNT_WIDTH-1:0] count_reg;

    always_ff @(posedge clk) begin
      if (reset_all) begin
        s1_reg    <= 1'b0;
        s2_reg    <= 1'b0;
        s3_reg    <= 1'b0;
        count_reg <= '0;
      end else begin
        s1_reg <= echo_high[gi];
        s2_reg <= s1_reg;
        s3_reg <= s2_reg;
        if (ch_reg == CH_W'(gi)) begin
          if (state_reg == DONE_OK) count_reg <= cnt_reg;
          else if (state_reg == DONE_TO) count_reg <= '1;
        end
      end
    end

    assign echo_sync[gi] = s2_reg;
    assign echo_rise[gi] = s2_reg & ~s3_reg;
    assign count_mem[gi] = count_reg;
  end

  assign echo_shift = echo_sync >> ch_reg;
  assign rise_shift = echo_rise >> ch_reg;
  assign echo_sel   = echo_shift[0];
  assign rise_sel   = rise_shift[0];
  assign ch_onehot  = N_CH'(1) << ch_reg;

  // First enabled channel at or after ch_reg, wrapping around.
  always_comb begin
    scan_ch    = ch_reg;
    scan_found = 1'b0;
    scan_idx   = 0;
    scan_mask  = '0;
    for (int i = 0; i < N_CH; i++) begin
      scan_idx = int'(ch_reg) + i;
      if (scan_idx >= N_CH) scan_idx = scan_idx - N_CH;
      scan_mask = mask_reg >> scan_idx;
      if (!scan_found && scan_mask[0]) begin
        scan_ch    = CH_W'(scan_idx);
        scan_found = 1'b1;
      end
    end
  end

  // Engine next-state logic. timer_reg counts the trigger length, then the
  // combined WAIT_ECHO+MEASURE time, then the holdoff gap.
  always_comb begin
    state_next = state_reg;
    ch_next    = ch_reg;
    timer_next = timer_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE: begin
        if (mask_reg != '0) begin
          ch_next    = scan_ch;
          timer_next = '0;
          state_next = TRIG;
        end
      end
      TRIG: begin
        if (timer_reg >= 32'(TRIG_CYCLES - 1)) begin
          timer_next = '0;
          state_next = WAIT_ECHO;
        end else begin
          timer_next = timer_reg + 32'd1;
        end
      end
      WAIT_ECHO: begin
        timer_next = timer_reg + 32'd1;
        if (rise_sel) begin
          cnt_next   = '0;
          state_next = MEASURE;
        end else if (timer_reg >= 32'(TIMEOUT - 1)) begin
          state_next = DONE_TO;
        end
      end
      MEASURE: begin
        timer_next = timer_reg + 32'd1;
        if (!echo_sel) begin
          state_next = DONE_OK;
        end else if (timer_reg >= 32'(TIMEOUT - 1)) begin
          state_next = DONE_TO;
        end else if (cnt_reg != '1) begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      DONE_OK, DONE_TO: begin
        timer_next = '0;
        state_next = HOLDOFF;
      end
      HOLDOFF: begin
        if (timer_reg >= 32'(GAP_CYCLES - 1)) begin
          timer_next = '0;
          ch_next    = (ch_reg == CH_W'(N_CH - 1)) ? '0 : ch_reg + 1'b1;
          state_next = IDLE;
        end else begin
          timer_next = timer_reg + 32'd1;
        end
      end
      default: state_next = IDLE;
    endcase
    if (restart) begin
      state_next = IDLE;
      ch_next    = '0;
      timer_next = '0;
    end
  end

  // The trigger is registered so that it lines up exactly with the TRIG state.
  assign pulse_next = (state_next == TRIG) ? (N_CH'(1) << ch_next) : '0;

  // A STATUS read clears whatever was visible to it, while a completion
  // landing in that same cycle is applied afterwards and therefore survives.
  always_comb begin
    ready_next   = stat_rd ? '0 : ready_reg;
    timeout_next = stat_rd ? '0 : timeout_reg;
    if (state_reg == DONE_OK) begin
      ready_next   = ready_next | ch_onehot;
      timeout_next = timeout_next & ~ch_onehot;
    end else if (state_reg == DONE_TO) begin
      ready_next   = ready_next | ch_onehot;
      timeout_next = timeout_next | ch_onehot;
    end
  end

  always_comb begin
    rd_mux = '0;
    if (addr == '0) begin
      rd_mux = 32'(ready_reg) | (32'(timeout_reg) << 16);
    end else if (addr == ADDR_W'(1)) begin
      rd_mux = control_word;
    end
    for (int i = 0; i < N_CH; i++) begin
      if (int'(addr) == i + 2) rd_mux = 32'(count_mem[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset_all) begin
      state_reg     <= IDLE;
      ch_reg        <= '0;
      timer_reg     <= '0;
      cnt_reg       <= '0;
      pulse_reg     <= '0;
      mask_reg      <= '0;
      ready_reg     <= '0;
      timeout_reg   <= '0;
      read_data_reg <= '0;
    end else begin
      state_reg   <= state_next;
      ch_reg      <= ch_next;
      timer_reg   <= timer_next;
      cnt_reg     <= cnt_next;
      pulse_reg   <= pulse_next;
      ready_reg   <= ready_next;
      timeout_reg <= timeout_next;
      if (ctrl_wr) mask_reg <= write_data[N_CH-1:0];
      if (read_en) read_data_reg <= rd_mux;
    end
  end

`ifdef ULTRA_SONIC_IRQ_EN
  logic [N_CH-1:0] irq_en_reg;
  logic            irq_reg;

  // Bit 31 of CONTROL is write-only (restart), so it always reads back as 0.
  assign control_word = (32'(mask_reg) | (32'(irq_en_reg) << 16)) & 32'h7FFF_FFFF;

  always_ff @(posedge clk) begin
    if (reset_all) begin
      irq_en_reg <= '0;
      irq_reg    <= 1'b0;
    end else begin
      if (ctrl_wr) irq_en_reg <= N_CH'(write_data[30:16]);
      irq_reg <= |(ready_reg & irq_en_reg);
    end
  end

  assign irq = irq_reg;
`else
  assign control_word = 32'(mask_reg);
  assign irq          = 1'b0;
`endif

  assign pulse_out = pulse_reg;
  assign read_data = read_data_reg;

endmodule

// File: tb/tb_ultra_sonic_array.sv
// Bench for ultra_sonic_array, with parameters scaled down for short runs.
// Register reads push their expected value (or accepted range) onto a
// scoreboard queue and pop it when read_data comes back. Trigger order is
// scoreboarded in the same way by a pulse_out monitor. A responder process
// plays the part of the sensors: it answers each trigger fall with an echo
// pulse of programmable delay and width.
module tb_ultra_sonic_array;
  localparam int N_CH        = 4;
  localparam int COUNT_WIDTH = 12;
  localparam int TRIG_CYCLES = 20;
  localparam int TIMEOUT     = 6000;
  localparam int GAP_CYCLES  = 200;
  localparam int ADDR_W      = 5;
  localparam logic [31:0] CNT_MAX = 32'h0000_0FFF;

  logic              clk = 1'b0;
  logic              reset_all;
  logic [N_CH-1:0]   echo_high;
  logic [N_CH-1:0]   pulse_out;
  logic [ADDR_W-1:0] addr;
  logic              read_en;
  logic              write_en;
  logic [31:0]       write_data;
  logic [31:0]       read_data;
  logic              irq;

  ultra_sonic_array #(
    .N_CH(N_CH), .COUNT_WIDTH(COUNT_WIDTH), .TRIG_CYCLES(TRIG_CYCLES),
    .TIMEOUT(TIMEOUT), .GAP_CYCLES(GAP_CYCLES), .ADDR_W(ADDR_W)
  ) dut (
    .clk(clk), .reset_all(reset_all), .echo_high(echo_high), .pulse_out(pulse_out),
    .addr(addr), .read_en(read_en), .write_en(write_en), .write_data(write_data),
    .read_data(read_data), .irq(irq)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] lo;
    logic [31:0] hi;
    string       tag;
  } exp_t;

  exp_t rd_q[$];
  int   trig_q[$];
  int   trig_seen = 0;
  logic mon_on = 1'b0;
  logic resp_en = 1'b0;
  int   resp_delay = 100;
  int   resp_width = 2000;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic check_range(input string tag, input logic [31:0] obs,
                             input logic [31:0] lo, input logic [31:0] hi);
    total++;
    assert (((obs >= lo) && (obs <= hi)) === 1'b1) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d..%0d", tag, obs, lo, hi);
    end
  endtask

  // Called with the bench sitting just after a posedge. Returns just after the
  // edge where the DUT captured the read.
  task automatic rd(input logic [ADDR_W-1:0] a, input logic [31:0] lo,
                    input logic [31:0] hi, input string tag);
    exp_t e;
    e.lo = lo; e.hi = hi; e.tag = tag;
    rd_q.push_back(e);
    addr = a; read_en = 1'b1;
    @(posedge clk); #1;
    read_en = 1'b0;
    e = rd_q.pop_front();
    if (e.lo == e.hi) check(e.tag, read_data, e.lo);
    else check_range(e.tag, read_data, e.lo, e.hi);
  endtask

  task automatic rde(input logic [ADDR_W-1:0] a, input logic [31:0] v, input string tag);
    rd(a, v, v, tag);
  endtask

  task automatic wr(input logic [ADDR_W-1:0] a, input logic [31:0] d);
    addr = a; write_data = d; write_en = 1'b1;
    @(posedge clk); #1;
    write_en = 1'b0;
  endtask

  task automatic rdwr(input logic [ADDR_W-1:0] a, input logic [31:0] d,
                      input logic [31:0] v, input string tag);
    exp_t e;
    e.lo = v; e.hi = v; e.tag = tag;
    rd_q.push_back(e);
    addr = a; write_data = d; write_en = 1'b1; read_en = 1'b1;
    @(posedge clk); #1;
    write_en = 1'b0; read_en = 1'b0;
    e = rd_q.pop_front();
    check(e.tag, read_data, e.lo);
  endtask

  task automatic wait_trig(input int target, input int budget, input string tag);
    int n;
    n = 0;
    while (trig_seen < target && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    check(tag, 32'(trig_seen >= target), 32'd1);
  endtask

  // Trigger monitor: checks order, one-hot, pulse width and holdoff gap.
  initial begin
    logic [N_CH-1:0] prev, cur, rises;
    int ch, last_fall, rise_cyc, expc;
    prev = '0; last_fall = -1; rise_cyc = 0; ch = 0; expc = 0;
    forever begin
      @(posedge clk); #1;
      if (mon_on) begin
        cur   = pulse_out;
        rises = cur & ~prev;
        if (rises != '0) begin
          for (int i = 0; i < N_CH; i++) if (rises[i]) ch = i;
          trig_seen++;
          check("trig_onehot", 32'($countones(cur)), 32'd1);
          check("trig_expected", 32'(trig_q.size() > 0), 32'd1);
          if (trig_q.size() > 0) begin
            expc = trig_q.pop_front();
            check("trig_order", 32'(ch), 32'(expc));
          end
          if (last_fall >= 0) check("trig_gap", 32'((cyc - last_fall) >= GAP_CYCLES), 32'd1);
          rise_cyc = cyc;
        end
        if ((prev & ~cur) != '0) begin
          check("trig_width", 32'(cyc - rise_cyc), 32'(TRIG_CYCLES));
          last_fall = cyc;
        end
        prev = cur;
      end
    end
  end

  // Sensor model: after a trigger falls, wait resp_delay cycles, then hold the
  // echo high for resp_width cycles.
  initial begin
    logic [N_CH-1:0] p_prev, p_cur;
    int k;
    echo_high = '0; p_prev = '0; k = 0;
    forever begin
      @(posedge clk); #1;
      p_cur = pulse_out;
      if (resp_en && ((p_prev & ~p_cur) != '0)) begin
        for (int i = 0; i < N_CH; i++) if (p_prev[i] && !p_cur[i]) k = i;
        repeat (resp_delay) @(posedge clk);
        #1; echo_high[k] = 1'b1;
        repeat (resp_width) @(posedge clk);
        #1; echo_high[k] = 1'b0;
        p_cur = pulse_out;
      end
      p_prev = p_cur;
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: observed=no finish expected=finish by cycle 60000");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base;
    reset_all = 1'b1; addr = '0; read_en = 1'b0; write_en = 1'b0; write_data = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_pulse_out", 32'(pulse_out), 32'd0);
    check("reset_read_data", read_data, 32'd0);
    check("reset_irq", 32'(irq), 32'd0);
    reset_all = 1'b0;
    mon_on = 1'b1;
    repeat (1000) @(posedge clk);
    #1;
    check("idle_no_trigger", 32'(trig_seen), 32'd0);
    rde(0, 32'd0, "status_reset");
    rde(1, 32'd0, "control_reset");
    rde(2, 32'd0, "count0_reset");

    // Single channel with a 2000-cycle echo; the mask is cleared mid-measurement.
    resp_delay = 100; resp_width = 2000; resp_en = 1'b1;
    trig_q.push_back(0);
    base = trig_seen;
    wr(1, 32'h0000_0001);
    wait_trig(base + 1, 500, "wait_trig_single");
    wr(1, 32'h0000_0000);
    repeat (TRIG_CYCLES + 100 + 2000 + 100) @(posedge clk);
    #1;
    rd(2, 32'd1998, 32'd2002, "count0_single");
    rde(0, 32'h0000_0001, "status_single");
    rde(0, 32'h0000_0000, "status_cleared");
    rde(1, 32'h0000_0000, "control_mask_cleared");

    // Timeout: the echo never rises.
    resp_en = 1'b0;
    trig_q.push_back(0);
    base = trig_seen;
    wr(1, 32'h0000_0001);
    wait_trig(base + 1, 500, "wait_trig_timeout");
    wr(1, 32'h0000_0000);
    repeat (TRIG_CYCLES + TIMEOUT + 50) @(posedge clk);
    #1;
    rde(2, CNT_MAX, "count0_timeout");
    rde(0, 32'h0001_0001, "status_timeout");

    // Saturation: the echo is longer than the count range but shorter than TIMEOUT.
    resp_en = 1'b1; resp_delay = 100; resp_width = 4500;
    trig_q.push_back(0);
    base = trig_seen;
    wr(1, 32'h0000_0001);
    wait_trig(base + 1, 500, "wait_trig_sat");
    wr(1, 32'h0000_0000);
    repeat (TRIG_CYCLES + 100 + 4500 + 100) @(posedge clk);
    #1;
    rde(2, CNT_MAX, "count0_saturated");
    rde(0, 32'h0000_0001, "status_saturated");

    // Round robin over mask 1011, started by a soft restart.
    resp_delay = 10; resp_width = 50;
    trig_q.push_back(0); trig_q.push_back(1); trig_q.push_back(3); trig_q.push_back(0);
    base = trig_seen;
    wr(1, 32'h8000_000B);
    wait_trig(base + 4, 3000, "wait_trig_rr");
    rdwr(1, 32'h0000_0000, 32'h0000_000B, "control_rw_old_value");
    repeat (400) @(posedge clk);
    #1;
    check("rr_trigger_count", 32'(trig_seen - base), 32'd4);
    rde(0, 32'h0000_000B, "status_round_robin");
    rd(3, 32'd48, 32'd52, "count1_rr");
    rd(5, 32'd48, 32'd52, "count3_rr");
    rde(4, 32'd0, "count2_never_triggered");
    rde(6, 32'd0, "oob_addr6");
    rd(5, 32'd48, 32'd52, "count3_again");
    rde(31, 32'd0, "oob_addr31");
    rde(1, 32'd0, "control_after_rw");

    // Writes to read-only addresses are ignored.
    wr(0, 32'hFFFF_FFFF);
    wr(4, 32'h0000_005A);
    rde(0, 32'd0, "status_write_ignored");
    rde(4, 32'd0, "count2_write_ignored");

    // IRQ enable bits in CONTROL.
    wr(1, 32'h7FFF_0000);
`ifdef ULTRA_SONIC_IRQ_EN
    rde(1, 32'h000F_0000, "control_irq_en_bits");
`else
    rde(1, 32'h0000_0000, "control_irq_en_bits");
`endif

    // Interrupt on channel 0 completion.
    resp_delay = 10; resp_width = 50;
    trig_q.push_back(0);
    base = trig_seen;
    wr(1, 32'h0001_0001);
    wait_trig(base + 1, 500, "wait_trig_irq");
    wr(1, 32'h0001_0000);
`ifdef ULTRA_SONIC_IRQ_EN
    begin
      int n;
      n = 0;
      while (irq !== 1'b1 && n < 500) begin
        @(posedge clk); #1;
        n++;
      end
    end
    check("irq_rise", 32'(irq), 32'd1);
    rde(0, 32'h0000_0001, "status_irq");
    check("irq_held_through_read", 32'(irq), 32'd1);
    @(posedge clk); #1;
    check("irq_drop", 32'(irq), 32'd0);
`else
    repeat (400) @(posedge clk);
    #1;
    check("irq_tied_low", 32'(irq), 32'd0);
    rde(0, 32'h0000_0001, "status_irq");
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
